// File: rtl/program_loader.sv
// Byte-stream program loader: receives BASE/LEN/payload/CHK frames and
// writes each payload byte into a ROM through the edit/unit/code/send port.
module program_loader #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       edit,
    output logic [7:0] unit,
    output logic [7:0] code,
    output logic       send,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_BASE,
        GET_LEN,
        GET_DATA,
        WRITE,
        GET_CHK
    } state_t;

    state_t          state;
    logic [7:0]      pointer;
    logic [7:0]      acc;
    logic [8:0]      count;
    logic [IW-1:0]   idle_cnt;
    logic            xfer;
    logic            timed_out;

    // Valid/ready: a byte moves on any rising edge where in_valid & in_ready.
    // in_ready is registered and is high only in the four GET states.
    assign xfer      = in_valid & in_ready;
    assign timed_out = !xfer && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            edit     <= 1'b0;
            send     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            unit     <= 8'h00;
            code     <= 8'h00;
            pointer  <= 8'h00;
            count    <= 9'd0;
            acc      <= 8'h00;
            idle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= GET_BASE;
                        error    <= 1'b0;
                        edit     <= 1'b1;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        idle_cnt <= '0;
                    end
                end

                GET_BASE, GET_LEN, GET_DATA, GET_CHK: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        case (state)
                            GET_BASE: begin
                                pointer <= in_data;
                                state   <= GET_LEN;
                            end
                            GET_LEN: begin
                                count <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                                acc   <= 8'h00;
                                state <= GET_DATA;
                            end
                            GET_DATA: begin
                                unit     <= pointer;
                                code     <= in_data;
                                send     <= 1'b1;
                                acc      <= acc + in_data;
                                in_ready <= 1'b0;
                                state    <= WRITE;
                            end
                            GET_CHK: begin
                                // Bytes already written stay in the ROM on a bad checksum.
                                if (in_data == acc) begin
                                    done <= 1'b1;
                                end else begin
                                    error <= 1'b1;
                                end
                                edit     <= 1'b0;
                                busy     <= 1'b0;
                                in_ready <= 1'b0;
                                state    <= IDLE;
                            end
                            default: ;
                        endcase
                    end else if (timed_out) begin
                        error    <= 1'b1;
                        edit     <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                WRITE: begin
                    send     <= 1'b0;
                    pointer  <= pointer + 8'h01;
                    count    <= count - 9'd1;
                    in_ready <= 1'b1;
                    state    <= (count == 9'd1) ? GET_CHK : GET_DATA;
                end

                default: begin
                    state    <= IDLE;
                    edit     <= 1'b0;
                    busy     <= 1'b0;
                    send     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
